// File: rtl/result_bcd_formatter.sv
// Binary-to-display formatter: serial double-dabble, range check, sign and error display.
// Optional build macro LEADING_ZERO_BLANK_EN enables leading-zero blanking and a floating minus.
module result_bcd_formatter #(
    parameter int IN_WIDTH  = 40,
    parameter int DIGITS    = 6,
    parameter int CONV_BITS = 20
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [IN_WIDTH-1:0]   i_value,
    input  logic                  i_sign,
    input  logic                  i_err,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam int CW = $clog2(CONV_BITS + 1);
    localparam logic [IN_WIDTH-1:0]  POS_MAX   = IN_WIDTH'(pow10(DIGITS) - 1);
    localparam logic [IN_WIDTH-1:0]  NEG_MAX   = IN_WIDTH'(pow10(DIGITS - 1) - 1);
    localparam logic [4*DIGITS-1:0]  RESET_BCD = {{(DIGITS-1){4'hF}}, 4'h0};
    localparam logic [4*DIGITS-1:0]  ERR_BCD   = {4'hE, {(DIGITS-1){4'hF}}};

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t                state_q, state_d;
    logic [CONV_BITS-1:0]  shift_q, shift_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic                  err_q, err_d;
    logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
    logic                  err_out_q, err_out_d;
    logic                  done_q, done_d;

    logic                  range_err;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   fmt;
    logic                  nonzero;

    assign range_err = i_err
                     | ((i_value >> CONV_BITS) != '0)
                     | (i_sign ? (i_value > NEG_MAX) : (i_value > POS_MAX));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            bcd_out_q <= RESET_BCD;
            err_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            bcd_out_q <= bcd_out_d;
            err_out_q <= err_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = range_err ? FORMAT : SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FORMAT;
            FORMAT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: nibbles >= 5 get +3 before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
    end

    always_comb begin
        nonzero = |bcd_q;
        fmt     = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 0; i < DIGITS; i++)
                if (bcd_q[4*i +: 4] != 4'd0) msd = i;
            for (int i = 1; i < DIGITS; i++) begin
                if (i > msd) fmt[4*i +: 4] = 4'hF;
                if (sign_q && nonzero && i == msd + 1) fmt[4*i +: 4] = 4'hA;
            end
        end
`else
        // Negative range leaves the top digit zero, so the minus always fits there.
        if (sign_q && nonzero) fmt[4*DIGITS-1 -: 4] = 4'hA;
`endif
    end

    always_comb begin
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        err_d     = err_q;
        bcd_out_d = bcd_out_q;
        err_out_d = err_out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                sign_d = i_sign;
                err_d  = range_err;
                if (!range_err) begin
                    shift_d = i_value[CONV_BITS-1:0];
                    bcd_d   = '0;
                    cnt_d   = CW'(CONV_BITS);
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[4*DIGITS-2:0], shift_q[CONV_BITS-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
            end
            FORMAT: begin
                bcd_out_d = err_q ? ERR_BCD : fmt;
                err_out_d = err_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy = (state_q != IDLE);
        o_bcd  = bcd_out_q;
        o_err  = err_out_q;
        o_done = done_q;
    end
endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed table-driven bench for result_bcd_formatter, plus abort/ignore/retrigger sequences.
module tb_result_bcd_formatter;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [39:0] i_value = '0;
    logic        i_sign = 1'b0;
    logic        i_err = 1'b0;
    logic [23:0] o_bcd;
    logic        o_busy, o_done, o_err;

    int n_chk = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    result_bcd_formatter dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_value(i_value),
        .i_sign(i_sign), .i_err(i_err), .o_bcd(o_bcd), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [23:0] E42 = 24'hFFFF42, E0 = 24'hFFFFF0, E305N = 24'hFFA305;
    localparam logic [23:0] E99999P = 24'hF99999, E7 = 24'hFFFFF7, E8 = 24'hFFFFF8;
`else
    localparam logic [23:0] E42 = 24'h000042, E0 = 24'h000000, E305N = 24'hA00305;
    localparam logic [23:0] E99999P = 24'h099999, E7 = 24'h000007, E8 = 24'h000008;
`endif

    typedef struct {
        logic [39:0] value;
        logic        sign;
        logic        err;
        logic [23:0] exp_bcd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Launch one conversion; lat = edges from accept to done (-1 on timeout).
    task automatic convert(input logic [39:0] v, input logic s, input logic e,
                           output int lat, output int busy_cnt);
        @(negedge i_clk);
        i_value = v; i_sign = s; i_err = e; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = -1; busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (o_done) begin lat = k; break; end
            if (o_busy) busy_cnt++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        int lat, bc, k1, k2, pulses;

        vecs[0]  = '{40'd123456,   1'b0, 1'b0, 24'h123456, 1'b0, 21};
        vecs[1]  = '{40'd42,       1'b0, 1'b0, E42,        1'b0, 21};
        vecs[2]  = '{40'd0,        1'b0, 1'b0, E0,         1'b0, 21};
        vecs[3]  = '{40'd305,      1'b1, 1'b0, E305N,      1'b0, 21};
        vecs[4]  = '{40'd99999,    1'b1, 1'b0, 24'hA99999, 1'b0, 21};
        vecs[5]  = '{40'd0,        1'b1, 1'b0, E0,         1'b0, 21};
        vecs[6]  = '{40'd999999,   1'b0, 1'b0, 24'h999999, 1'b0, 21};
        vecs[7]  = '{40'd100000,   1'b0, 1'b0, 24'h100000, 1'b0, 21};
        vecs[8]  = '{40'd99999,    1'b0, 1'b0, E99999P,    1'b0, 21};
        vecs[9]  = '{40'd1000000,  1'b0, 1'b0, 24'hEFFFFF, 1'b1, 1};
        vecs[10] = '{40'd100000,   1'b1, 1'b0, 24'hEFFFFF, 1'b1, 1};
        vecs[11] = '{40'd5,        1'b0, 1'b1, 24'hEFFFFF, 1'b1, 1};
        vecs[12] = '{40'd1048576,  1'b0, 1'b0, 24'hEFFFFF, 1'b1, 1};
        vecs[13] = '{40'h80_0000_0000, 1'b0, 1'b0, 24'hEFFFFF, 1'b1, 1};

        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        chk("reset_bcd",  o_bcd,  24'hFFFFF0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_done", o_done, 1'b0);
        chk("reset_err",  o_err,  1'b0);

        for (int i = 0; i < 14; i++) begin
            convert(vecs[i].value, vecs[i].sign, vecs[i].err, lat, bc);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_lat);
            chk($sformatf("v%0d_bcd", i), o_bcd, vecs[i].exp_bcd);
            chk($sformatf("v%0d_err", i), o_err, vecs[i].exp_err);
            @(negedge i_clk);
            chk($sformatf("v%0d_done_width", i), o_done, 1'b0);
            chk($sformatf("v%0d_bcd_hold", i), o_bcd, vecs[i].exp_bcd);
        end

        // Start while busy is dropped, not queued.
        @(negedge i_clk);
        i_value = 40'd123456; i_sign = 1'b0; i_err = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (k == 4) begin i_start = 1'b1; i_value = 40'd7; end
            if (k == 5) begin i_start = 1'b0; i_value = 40'd123456; end
            if (o_done) begin lat = k; break; end
            @(negedge i_clk);
        end
        chk("ignore_latency", lat, 21);
        chk("ignore_bcd", o_bcd, 24'h123456);
        @(negedge i_clk);
        chk("ignore_not_queued", o_busy, 1'b0);
        convert(40'd7, 1'b0, 1'b0, lat, bc);
        chk("after_ignore_bcd", o_bcd, E7);

        // Reset mid-conversion aborts without done and clears a latched error.
        convert(40'd5, 1'b0, 1'b1, lat, bc);
        chk("pre_abort_err", o_err, 1'b1);
        @(negedge i_clk);
        i_value = 40'd123456; i_err = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            if (o_done) pulses++;
            @(negedge i_clk);
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_bcd",  o_bcd,  24'hFFFFF0);
        chk("abort_err",  o_err,  1'b0);
        for (int k = 0; k < 30; k++) begin
            if (o_done) pulses++;
            @(negedge i_clk);
        end
        chk("abort_no_done", pulses, 0);
        convert(40'd8, 1'b0, 1'b0, lat, bc);
        chk("after_abort_latency", lat, 21);
        chk("after_abort_bcd", o_bcd, E8);

        // Held start re-triggers on the IDLE cycle after done.
        @(negedge i_clk);
        i_value = 40'd42; i_sign = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        k1 = -1; k2 = -1;
        for (int k = 0; k < 100; k++) begin
            if (o_done) begin
                if (k1 < 0) k1 = k;
                else begin k2 = k; i_start = 1'b0; break; end
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        chk("retrig_first", k1, 21);
        chk("retrig_second", k2, 43);
        chk("retrig_bcd", o_bcd, E42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
